// File: rtl/camera_pkg.sv
// Shared types and reset-default crop windows for the still-capture sequencer.
// Coordinates are 11-bit sensor pixels; window ends are exclusive.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    coord_t x_start;
    coord_t x_end;
    coord_t y_start;
    coord_t y_end;
  } window_t;

  localparam window_t DEF_PAN_WIN  = '{x_start: 11'd284, x_end: 11'd1004,
                                       y_start: 11'd4,   y_end: 11'd724};
  // 512x512 centred inside the 720x720 pan window
  localparam window_t DEF_ZOOM_WIN = '{x_start: 11'd104, x_end: 11'd616,
                                       y_start: 11'd104, y_end: 11'd616};
  localparam coord_t  DEF_SIZE     = 11'd512;

  function automatic coord_t clamp_even(input coord_t v, input coord_t lo, input coord_t hi);
    coord_t r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return {r[10:1], 1'b0};
  endfunction

endpackage

// File: rtl/crop_window_calc.sv
// Clamps pan/resolution requests and derives pan and centred zoom windows.
// Results register on load (one-cycle latency) and act as the shadow copy.
module crop_window_calc
  import camera_pkg::*;
#(
  parameter int PAN_WIDTH   = 720,
  parameter int PAN_X_BASE  = 284,
  parameter int PAN_Y_START = 4,
  parameter int MAX_X_PAN   = 280,
  parameter int MIN_RES     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [10:0] x_pan,
  input  logic [10:0] x_res,
  input  logic [10:0] y_res,
  output window_t     pan_win,
  output window_t     zoom_win
);

  coord_t  xp;
  coord_t  rx;
  coord_t  ry;
  window_t pan_nxt;
  window_t zoom_nxt;

  always_comb begin
    xp = (x_pan > coord_t'(MAX_X_PAN)) ? coord_t'(MAX_X_PAN) : x_pan;
    rx = clamp_even(x_res, coord_t'(MIN_RES), coord_t'(PAN_WIDTH));
    ry = clamp_even(y_res, coord_t'(MIN_RES), coord_t'(PAN_WIDTH));

    pan_nxt.x_start = coord_t'(PAN_X_BASE) + xp;
    pan_nxt.x_end   = pan_nxt.x_start + coord_t'(PAN_WIDTH);
    pan_nxt.y_start = coord_t'(PAN_Y_START);
    pan_nxt.y_end   = pan_nxt.y_start + coord_t'(PAN_WIDTH);

    // rx/ry are even, so the halving is exact and the crop stays centred
    zoom_nxt.x_start = (coord_t'(PAN_WIDTH) - rx) >> 1;
    zoom_nxt.x_end   = zoom_nxt.x_start + rx;
    zoom_nxt.y_start = (coord_t'(PAN_WIDTH) - ry) >> 1;
    zoom_nxt.y_end   = zoom_nxt.y_start + ry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pan_win  <= DEF_PAN_WIN;
      zoom_win <= DEF_ZOOM_WIN;
    end else if (load) begin
      pan_win  <= pan_nxt;
      zoom_win <= zoom_nxt;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one still capture: arm on start edge, apply shadowed crop windows and start jpeg on the
// next frame end, finish on image_valid or after TIMEOUT_FRAMES frame ends. image_valid -> done_out: 2 cycles.
module capture_sequencer
  import camera_pkg::*;
#(
  parameter int PAN_WIDTH      = 720,
  parameter int PAN_X_BASE     = 284,
  parameter int PAN_Y_START    = 4,
  parameter int MAX_X_PAN      = 280,
  parameter int MIN_RES        = 16,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        start_capture_in,
  input  logic [10:0] x_pan_in,
  input  logic [10:0] x_resolution_in,
  input  logic [10:0] y_resolution_in,
  input  logic        frame_valid_in,
  input  logic        image_valid_in,
  input  logic [15:0] image_address_in,
  output logic [10:0] pan_x_start_out,
  output logic [10:0] pan_x_end_out,
  output logic [10:0] pan_y_start_out,
  output logic [10:0] pan_y_end_out,
  output logic [10:0] zoom_x_start_out,
  output logic [10:0] zoom_x_end_out,
  output logic [10:0] zoom_y_start_out,
  output logic [10:0] zoom_y_end_out,
  output logic [10:0] x_size_out,
  output logic [10:0] y_size_out,
  output logic        jpeg_start_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        timeout_out,
  output logic [15:0] bytes_available_out
);

  localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

  state_t           state;
  state_t           state_nxt;
  logic             start_d;
  logic             fv_d;
  logic             start_pulse;
  logic             frame_end;
  logic             load;
  logic             fe_terminal;
  logic [CNT_W-1:0] fe_cnt;
  window_t          shadow_pan;
  window_t          shadow_zoom;
  window_t          pan_win;
  window_t          zoom_win;
  logic [10:0]      x_size;
  logic [10:0]      y_size;
  logic             done;
  logic             timeout;
  logic [15:0]      bytes_avail;
  logic             busy;
  logic             jpeg_start;

  assign start_pulse = start_capture_in & ~start_d;
  assign frame_end   = fv_d & ~frame_valid_in;
  assign load        = start_pulse && (state == IDLE);
  // The arming frame end counts as the first of the allowed frames
  assign fe_terminal = frame_end && (fe_cnt == CNT_W'(TIMEOUT_FRAMES - 1));

  crop_window_calc #(
    .PAN_WIDTH   (PAN_WIDTH),
    .PAN_X_BASE  (PAN_X_BASE),
    .PAN_Y_START (PAN_Y_START),
    .MAX_X_PAN   (MAX_X_PAN),
    .MIN_RES     (MIN_RES)
  ) u_calc (
    .clk      (clock_in),
    .rst_n    (reset_n_in),
    .load     (load),
    .x_pan    (x_pan_in),
    .x_res    (x_resolution_in),
    .y_res    (y_resolution_in),
    .pan_win  (shadow_pan),
    .zoom_win (shadow_zoom)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    jpeg_start = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse) state_nxt = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (frame_end) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        jpeg_start = 1'b1;
        if (image_valid_in || fe_terminal) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      start_d <= 1'b0;
      fv_d    <= 1'b0;
    end else begin
      start_d <= start_capture_in;
      fv_d    <= frame_valid_in;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      fe_cnt      <= '0;
      pan_win     <= DEF_PAN_WIN;
      zoom_win    <= DEF_ZOOM_WIN;
      x_size      <= DEF_SIZE;
      y_size      <= DEF_SIZE;
      done        <= 1'b0;
      timeout     <= 1'b0;
      bytes_avail <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) begin
            fe_cnt      <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            bytes_avail <= '0;
          end
        end
        ARMED: begin
          // Whole-window swap between frames so no frame sees a mixed window
          if (frame_end) begin
            fe_cnt   <= fe_cnt + CNT_W'(1);
            pan_win  <= shadow_pan;
            zoom_win <= shadow_zoom;
            x_size   <= shadow_zoom.x_end - shadow_zoom.x_start;
            y_size   <= shadow_zoom.y_end - shadow_zoom.y_start;
          end
        end
        CAPTURE: begin
          if (image_valid_in) begin
            bytes_avail <= image_address_in + 16'd4;
          end else if (frame_end) begin
            fe_cnt <= fe_cnt + CNT_W'(1);
            if (fe_terminal) begin
              timeout     <= 1'b1;
              bytes_avail <= '0;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pan_x_start_out     = pan_win.x_start;
  assign pan_x_end_out       = pan_win.x_end;
  assign pan_y_start_out     = pan_win.y_start;
  assign pan_y_end_out       = pan_win.y_end;
  assign zoom_x_start_out    = zoom_win.x_start;
  assign zoom_x_end_out      = zoom_win.x_end;
  assign zoom_y_start_out    = zoom_win.y_start;
  assign zoom_y_end_out      = zoom_win.y_end;
  assign x_size_out          = x_size;
  assign y_size_out          = y_size;
  assign jpeg_start_out      = jpeg_start;
  assign busy_out            = busy;
  assign done_out            = done;
  assign timeout_out         = timeout;
  assign bytes_available_out = bytes_avail;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized capture scenarios checked against a transaction-level model of the sequencer.
// Expected windows come from the clamp/centre rules; outcomes from the bench's own event schedule.
module tb_capture_sequencer;

  logic        clock_in = 1'b0;
  logic        reset_n_in;
  logic        start_capture_in;
  logic [10:0] x_pan_in;
  logic [10:0] x_resolution_in;
  logic [10:0] y_resolution_in;
  logic        frame_valid_in;
  logic        image_valid_in;
  logic [15:0] image_address_in;
  logic [10:0] pan_x_start_out;
  logic [10:0] pan_x_end_out;
  logic [10:0] pan_y_start_out;
  logic [10:0] pan_y_end_out;
  logic [10:0] zoom_x_start_out;
  logic [10:0] zoom_x_end_out;
  logic [10:0] zoom_y_start_out;
  logic [10:0] zoom_y_end_out;
  logic [10:0] x_size_out;
  logic [10:0] y_size_out;
  logic        jpeg_start_out;
  logic        busy_out;
  logic        done_out;
  logic        timeout_out;
  logic [15:0] bytes_available_out;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_cur[10];
  int    exp_nxt[10];
  string names[10] = '{"pan_xs", "pan_xe", "pan_ys", "pan_ye", "zoom_xs",
                       "zoom_xe", "zoom_ys", "zoom_ye", "x_size", "y_size"};

  always #5 clock_in = ~clock_in;

  capture_sequencer dut (
    .clock_in            (clock_in),
    .reset_n_in          (reset_n_in),
    .start_capture_in    (start_capture_in),
    .x_pan_in            (x_pan_in),
    .x_resolution_in     (x_resolution_in),
    .y_resolution_in     (y_resolution_in),
    .frame_valid_in      (frame_valid_in),
    .image_valid_in      (image_valid_in),
    .image_address_in    (image_address_in),
    .pan_x_start_out     (pan_x_start_out),
    .pan_x_end_out       (pan_x_end_out),
    .pan_y_start_out     (pan_y_start_out),
    .pan_y_end_out       (pan_y_end_out),
    .zoom_x_start_out    (zoom_x_start_out),
    .zoom_x_end_out      (zoom_x_end_out),
    .zoom_y_start_out    (zoom_y_start_out),
    .zoom_y_end_out      (zoom_y_end_out),
    .x_size_out          (x_size_out),
    .y_size_out          (y_size_out),
    .jpeg_start_out      (jpeg_start_out),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .timeout_out         (timeout_out),
    .bytes_available_out (bytes_available_out)
  );

  task automatic check_val(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int obs(input int i);
    case (i)
      0:       return int'(pan_x_start_out);
      1:       return int'(pan_x_end_out);
      2:       return int'(pan_y_start_out);
      3:       return int'(pan_y_end_out);
      4:       return int'(zoom_x_start_out);
      5:       return int'(zoom_x_end_out);
      6:       return int'(zoom_y_start_out);
      7:       return int'(zoom_y_end_out);
      8:       return int'(x_size_out);
      default: return int'(y_size_out);
    endcase
  endfunction

  task automatic check_win(input string tag);
    for (int i = 0; i < 10; i++) check_val({tag, ".", names[i]}, obs(i), exp_cur[i]);
  endtask

  task automatic check_flags(input string tag, input int busy, input int jpeg, input int done,
                             input int tmo, input int bytes);
    check_val({tag, ".busy"}, int'(busy_out), busy);
    check_val({tag, ".jpeg"}, int'(jpeg_start_out), jpeg);
    check_val({tag, ".done"}, int'(done_out), done);
    check_val({tag, ".timeout"}, int'(timeout_out), tmo);
    check_val({tag, ".bytes"}, int'(bytes_available_out), bytes);
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic set_defaults();
    exp_cur = '{284, 1004, 4, 724, 104, 616, 104, 616, 512, 512};
  endtask

  task automatic model_win(input int pan, input int xr, input int yr);
    int xp, rx, ry;
    xp = (pan > 280) ? 280 : pan;
    rx = clampi(xr, 16, 720);
    rx = rx - (rx % 2);
    ry = clampi(yr, 16, 720);
    ry = ry - (ry % 2);
    exp_nxt = '{284 + xp, 1004 + xp, 4, 724, (720 - rx) / 2, (720 + rx) / 2,
                (720 - ry) / 2, (720 + ry) / 2, rx, ry};
  endtask

  // mode 0: no image_valid (timeout); mode 1: image_valid in blanking after frame end k;
  // mode 2: image_valid coincident with frame end k (k=4 races the timeout).
  task automatic run_capture(input string tag, input int pan, input int xr, input int yr,
                             input bit mid, input int mode, input int k, input int addr,
                             input bit poke);
    int fe;
    bit fin;
    bit ok;
    int want_bytes;
    int want_tmo;
    model_win(pan, xr, yr);
    image_valid_in = 1'b0;
    if (mid) begin
      frame_valid_in = 1'b1;
      repeat ($urandom_range(2, 5)) tick();
    end else begin
      frame_valid_in = 1'b0;
      tick();
    end
    x_pan_in         = 11'(pan);
    x_resolution_in  = 11'(xr);
    y_resolution_in  = 11'(yr);
    start_capture_in = 1'b1;
    tick();
    check_flags({tag, ".armed"}, 1, 0, 0, 0, 0);
    check_win({tag, ".armed"});
    start_capture_in = 1'b0;
    x_pan_in         = 11'($urandom);
    x_resolution_in  = 11'($urandom);
    y_resolution_in  = 11'($urandom);
    frame_valid_in   = 1'b1;
    for (int a = 0; a < 6; a++) begin
      if (poke && a == 1) begin
        start_capture_in = 1'b1;
        image_valid_in   = 1'b1;
        image_address_in = 16'($urandom);
      end
      if (poke && a == 2) begin
        start_capture_in = 1'b0;
        image_valid_in   = 1'b0;
      end
      tick();
    end
    check_win({tag, ".hold"});
    check_flags({tag, ".hold"}, 1, 0, 0, 0, 0);
    frame_valid_in = 1'b0;
    tick();
    exp_cur = exp_nxt;
    check_win({tag, ".applied"});
    check_flags({tag, ".capture"}, 1, 1, 0, 0, 0);
    fe  = 1;
    fin = 1'b0;
    ok  = 1'b0;
    while (!fin) begin
      if (mode == 1 && fe == k) begin
        repeat ($urandom_range(0, 2)) tick();
        image_valid_in   = 1'b1;
        image_address_in = 16'(addr);
        tick();
        fin = 1'b1;
        ok  = 1'b1;
      end else begin
        repeat ($urandom_range(1, 3)) tick();
        frame_valid_in = 1'b1;
        repeat ($urandom_range(3, 8)) tick();
        frame_valid_in = 1'b0;
        if (mode == 2 && fe + 1 == k) begin
          image_valid_in   = 1'b1;
          image_address_in = 16'(addr);
        end
        tick();
        fe++;
        if (mode == 2 && fe == k) begin
          fin = 1'b1;
          ok  = 1'b1;
        end else if (fe == 4) begin
          fin = 1'b1;
        end else begin
          check_flags({tag, ".wait"}, 1, 1, 0, 0, 0);
        end
      end
    end
    want_bytes = ok ? ((addr + 4) % 65536) : 0;
    want_tmo   = ok ? 0 : 1;
    check_val({tag, ".done_lat"}, int'(done_out), 0);
    check_val({tag, ".busy_end"}, int'(busy_out), 0);
    check_val({tag, ".tmo_early"}, int'(timeout_out), want_tmo);
    image_valid_in = 1'b0;
    tick();
    check_flags({tag, ".done"}, 0, 0, 1, want_tmo, want_bytes);
    check_win({tag, ".final"});
  endtask

  initial begin
    int pan, xr, yr, mode, k;
    reset_n_in       = 1'b1;
    start_capture_in = 1'b0;
    x_pan_in         = '0;
    x_resolution_in  = '0;
    y_resolution_in  = '0;
    frame_valid_in   = 1'b0;
    image_valid_in   = 1'b0;
    image_address_in = '0;
    set_defaults();
    #2 reset_n_in = 1'b0;
    #1;
    check_win("reset");
    check_flags("reset", 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset_n_in = 1'b1;
    tick();
    check_win("post_reset");
    check_flags("post_reset", 0, 0, 0, 0, 0);

    run_capture("tp1", 0, 512, 512, 1'b0, 1, 1, 39996, 1'b1);
    run_capture("tp2", 100, 200, 400, 1'b0, 0, 0, 0, 1'b0);
    run_capture("tp3", 37, 300, 150, 1'b1, 2, 4, 12345, 1'b0);
    run_capture("tp4", 500, 7, 900, 1'b0, 2, 2, 65534, 1'b1);

    for (int it = 0; it < 12; it++) begin
      pan  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 400));
      xr   = int'($urandom_range(0, 1023));
      yr   = int'($urandom_range(0, 1023));
      mode = int'($urandom_range(0, 2));
      k    = (mode == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(2, 4));
      run_capture($sformatf("rnd%0d", it), pan, xr, yr, 1'($urandom_range(0, 1)), mode, k,
                  int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    model_win(200, 100, 300);
    frame_valid_in = 1'b0;
    tick();
    x_pan_in         = 11'd200;
    x_resolution_in  = 11'd100;
    y_resolution_in  = 11'd300;
    start_capture_in = 1'b1;
    tick();
    start_capture_in = 1'b0;
    frame_valid_in   = 1'b1;
    repeat (4) tick();
    frame_valid_in = 1'b0;
    tick();
    exp_cur = exp_nxt;
    check_win("rst.pre");
    check_flags("rst.pre", 1, 1, 0, 0, 0);
    #2 reset_n_in = 1'b0;
    #1;
    set_defaults();
    check_win("rst.async");
    check_flags("rst.async", 0, 0, 0, 0, 0);
    tick();
    reset_n_in = 1'b1;
    tick();
    check_win("rst.after");
    check_flags("rst.after", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
